// File: rtl/wb_ctrl.sv
// wb_ctrl: MIPS writeback controller with load wait, pending-load scoreboard and optional forwarding (WB_FWD_EN)
module wb_ctrl #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          In_valid,
  output logic          In_ready,
  input  logic [5:0]    In_op,
  input  logic [5:0]    In_funct,
  input  logic [AW-1:0] In_rt,
  input  logic [AW-1:0] In_rd,
  input  logic [DW-1:0] In_result,
  input  logic          Mem_rvalid,
  input  logic [DW-1:0] Mem_rdata,
  output logic          We,
  output logic [AW-1:0] Waddr,
  output logic [DW-1:0] Wdata,
  output logic [31:0]   Busy,
  output logic          Retired,
  output logic          Timeout
`ifdef WB_FWD_EN
  ,
  input  logic [AW-1:0] Rd_addr1,
  input  logic [AW-1:0] Rd_addr2,
  output logic          Fwd_hit1,
  output logic          Fwd_hit2,
  output logic [DW-1:0] Fwd_data1,
  output logic [DW-1:0] Fwd_data2
`endif
);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [5:0] R_FORM = 6'h00, JAL = 6'h03, ADDI = 6'h08, ADDIU = 6'h09,
                         SLTI = 6'h0A, SLTIU = 6'h0B, ANDI = 6'h0C, ORI = 6'h0D,
                         XORI = 6'h0E, LW = 6'h23;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04,
                         F_SRLV = 6'h06, F_SRAV = 6'h07, F_JALR = 6'h09, F_ADD = 6'h20,
                         F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2A,
                         F_SLTU = 6'h2B;
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] ld_dest, ld_dest_n, dest, waddr_n;
  logic [DW-1:0] wdata_n;
  logic [31:0] busy_n;
  logic we_n, ret_n, to_n, wq, rf_ok, xfer, is_lw;
  assign In_ready = state == IDLE;
  assign xfer = In_valid && In_ready;
  assign is_lw = In_op == LW;
  assign rf_ok = In_funct inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                                  F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_JALR};
  assign wq = (In_op == R_FORM) ? rf_ok : In_op inside {ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, JAL, LW};
  assign dest = (In_op == R_FORM) ? In_rd : (In_op == JAL) ? AW'(31) : In_rt;
`ifdef WB_FWD_EN
  assign Fwd_hit1 = We && Waddr == Rd_addr1 && Waddr != '0;
  assign Fwd_hit2 = We && Waddr == Rd_addr2 && Waddr != '0;
  assign Fwd_data1 = Fwd_hit1 ? Wdata : '0;
  assign Fwd_data2 = Fwd_hit2 ? Wdata : '0;
`endif
  // Next-state and next registered-output values; loads park in WAIT_LOAD until data or timeout
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ld_dest_n = ld_dest;
    we_n = 1'b0;
    ret_n = 1'b0;
    waddr_n = Waddr;
    wdata_n = Wdata;
    busy_n = Busy;
    to_n = Timeout;
    case (state)
      IDLE: begin
        if (xfer && is_lw) begin
          state_n = WAIT_LOAD;
          ld_dest_n = dest;
          cnt_n = '0;
          busy_n = Busy | ((dest != '0) ? (32'd1 << dest) : 32'd0);
        end else if (xfer) begin
          we_n = wq && dest != '0;
          waddr_n = dest;
          wdata_n = In_result;
          ret_n = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (Mem_rvalid) begin
          state_n = IDLE;
          we_n = ld_dest != '0;
          waddr_n = ld_dest;
          wdata_n = Mem_rdata;
          busy_n = Busy & ~(32'd1 << ld_dest);
          ret_n = 1'b1;
        end else if (cnt == CW'(LOAD_TIMEOUT - 1)) begin
          state_n = ERR;
          cnt_n = CW'(LOAD_TIMEOUT);
          to_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end
  // State and registered outputs; reset abandons any pending load
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      cnt <= '0;
      ld_dest <= '0;
      We <= 1'b0;
      Waddr <= '0;
      Wdata <= '0;
      Busy <= '0;
      Retired <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ld_dest <= ld_dest_n;
      We <= we_n;
      Waddr <= waddr_n;
      Wdata <= wdata_n;
      Busy <= busy_n;
      Retired <= ret_n;
      Timeout <= to_n;
    end
  end
endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed table-driven bench for wb_ctrl plus load, timeout and reset sequences
module tb_wb_ctrl;
  localparam int DW = 32, AW = 5, LT = 15;
  logic CLK = 1'b0, RST_N = 1'b0, In_valid = 1'b0, Mem_rvalid = 1'b0;
  logic [5:0] In_op = '0, In_funct = '0;
  logic [AW-1:0] In_rt = '0, In_rd = '0;
  logic [DW-1:0] In_result = '0, Mem_rdata = '0;
  logic In_ready, We, Retired, Timeout;
  logic [AW-1:0] Waddr;
  logic [DW-1:0] Wdata;
  logic [31:0] Busy;
  int n_chk = 0, n_fail = 0;
`ifdef WB_FWD_EN
  logic [AW-1:0] Rd_addr1 = '0, Rd_addr2 = '0;
  logic Fwd_hit1, Fwd_hit2;
  logic [DW-1:0] Fwd_data1, Fwd_data2;
`endif
  wb_ctrl #(.DW(DW), .AW(AW), .LOAD_TIMEOUT(LT)) dut (
    .CLK(CLK), .RST_N(RST_N), .In_valid(In_valid), .In_ready(In_ready),
    .In_op(In_op), .In_funct(In_funct), .In_rt(In_rt), .In_rd(In_rd),
    .In_result(In_result), .Mem_rvalid(Mem_rvalid), .Mem_rdata(Mem_rdata),
    .We(We), .Waddr(Waddr), .Wdata(Wdata), .Busy(Busy), .Retired(Retired),
    .Timeout(Timeout)
`ifdef WB_FWD_EN
    , .Rd_addr1(Rd_addr1), .Rd_addr2(Rd_addr2), .Fwd_hit1(Fwd_hit1), .Fwd_hit2(Fwd_hit2),
    .Fwd_data1(Fwd_data1), .Fwd_data2(Fwd_data2)
`endif
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [31:0] res;
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
  } vec_t;
  vec_t v[12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " We"}, 32'(We), 0);
    chk({tag, " Waddr"}, 32'(Waddr), 0);
    chk({tag, " Wdata"}, Wdata, 0);
    chk({tag, " Busy"}, Busy, 0);
    chk({tag, " Retired"}, 32'(Retired), 0);
    chk({tag, " Timeout"}, 32'(Timeout), 0);
    chk({tag, " In_ready"}, 32'(In_ready), 1);
  endtask
  task automatic issue(input logic [5:0] op, input logic [4:0] rt);
    In_valid = 1'b1;
    In_op = op;
    In_funct = '0;
    In_rt = rt;
    In_rd = '0;
    In_result = 32'h1234;
    step();
    In_valid = 1'b0;
  endtask
  initial begin
    v[0]  = '{6'h08, 6'h00, 5'd9,  5'd0,  32'd45,       1'b1, 5'd9,  32'd45};
    v[1]  = '{6'h00, 6'h20, 5'd3,  5'd0,  32'd7,        1'b0, 5'd0,  32'd7};
    v[2]  = '{6'h00, 6'h08, 5'd3,  5'd5,  32'd100,      1'b0, 5'd5,  32'd100};
    v[3]  = '{6'h2B, 6'h00, 5'd4,  5'd0,  32'd11,       1'b0, 5'd4,  32'd11};
    v[4]  = '{6'h03, 6'h00, 5'd2,  5'd3,  32'd8,        1'b1, 5'd31, 32'd8};
    v[5]  = '{6'h00, 6'h00, 5'd1,  5'd12, 32'h55,       1'b1, 5'd12, 32'h55};
    v[6]  = '{6'h00, 6'h09, 5'd1,  5'd31, 32'h40,       1'b1, 5'd31, 32'h40};
    v[7]  = '{6'h04, 6'h00, 5'd6,  5'd2,  32'd1,        1'b0, 5'd6,  32'd1};
    v[8]  = '{6'h00, 6'h3F, 5'd1,  5'd7,  32'd77,       1'b0, 5'd7,  32'd77};
    v[9]  = '{6'h0D, 6'h00, 5'd13, 5'd1,  32'hF0F0,     1'b1, 5'd13, 32'hF0F0};
    v[10] = '{6'h3F, 6'h00, 5'd14, 5'd1,  32'd3,        1'b0, 5'd14, 32'd3};
    v[11] = '{6'h00, 6'h2B, 5'd1,  5'd17, 32'hFFFFFFFF, 1'b1, 5'd17, 32'hFFFFFFFF};
    step();
    step();
    chk_reset("reset");
    RST_N = 1'b1;
    step();
    for (int i = 0; i < 12; i++) begin
      In_valid = 1'b1;
      In_op = v[i].op;
      In_funct = v[i].funct;
      In_rt = v[i].rt;
      In_rd = v[i].rd;
      In_result = v[i].res;
      step();
      chk($sformatf("vec%0d We", i), 32'(We), 32'(v[i].we));
      chk($sformatf("vec%0d Waddr", i), 32'(Waddr), 32'(v[i].wa));
      chk($sformatf("vec%0d Wdata", i), Wdata, v[i].wd);
      chk($sformatf("vec%0d Retired", i), 32'(Retired), 1);
      chk($sformatf("vec%0d In_ready", i), 32'(In_ready), 1);
    end
    In_valid = 1'b0;
    step();
    chk("idle We", 32'(We), 0);
    chk("idle Retired", 32'(Retired), 0);
`ifdef WB_FWD_EN
    Rd_addr1 = 5'd9;
    Rd_addr2 = 5'd3;
    In_valid = 1'b1;
    In_op = 6'h08;
    In_rt = 5'd9;
    In_result = 32'd45;
    step();
    In_valid = 1'b0;
    chk("fwd hit1", 32'(Fwd_hit1), 1);
    chk("fwd data1", Fwd_data1, 32'd45);
    chk("fwd hit2", 32'(Fwd_hit2), 0);
    chk("fwd data2", Fwd_data2, 0);
    step();
    chk("fwd hit1 after", 32'(Fwd_hit1), 0);
`endif
    issue(6'h23, 5'd10);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw wait%0d Busy", i), Busy, 32'h0000_0400);
      chk($sformatf("lw wait%0d In_ready", i), 32'(In_ready), 0);
      chk($sformatf("lw wait%0d We", i), 32'(We), 0);
      if (i < 2) step();
    end
    Mem_rvalid = 1'b1;
    Mem_rdata = 32'hDEAD;
    step();
    Mem_rvalid = 1'b0;
    chk("lw We", 32'(We), 1);
    chk("lw Waddr", 32'(Waddr), 10);
    chk("lw Wdata", Wdata, 32'hDEAD);
    chk("lw Busy", Busy, 0);
    chk("lw Retired", 32'(Retired), 1);
    chk("lw In_ready", 32'(In_ready), 1);
    step();
    chk("lw We drop", 32'(We), 0);
    issue(6'h23, 5'd11);
    for (int i = 0; i < LT - 1; i++) step();
    chk("edge pre Timeout", 32'(Timeout), 0);
    chk("edge pre In_ready", 32'(In_ready), 0);
    Mem_rvalid = 1'b1;
    Mem_rdata = 32'hBEEF;
    step();
    Mem_rvalid = 1'b0;
    chk("edge We", 32'(We), 1);
    chk("edge Waddr", 32'(Waddr), 11);
    chk("edge Wdata", Wdata, 32'hBEEF);
    chk("edge Timeout", 32'(Timeout), 0);
    chk("edge Busy", Busy, 0);
    chk("edge In_ready", 32'(In_ready), 1);
    issue(6'h23, 5'd12);
    for (int i = 0; i < LT - 1; i++) step();
    chk("to pre Timeout", 32'(Timeout), 0);
    step();
    chk("to Timeout", 32'(Timeout), 1);
    chk("to In_ready", 32'(In_ready), 0);
    chk("to Busy", Busy, 32'h0000_1000);
    chk("to We", 32'(We), 0);
    Mem_rvalid = 1'b1;
    In_valid = 1'b1;
    In_op = 6'h08;
    In_rt = 5'd9;
    step();
    step();
    Mem_rvalid = 1'b0;
    In_valid = 1'b0;
    chk("err We", 32'(We), 0);
    chk("err Retired", 32'(Retired), 0);
    chk("err Timeout", 32'(Timeout), 1);
    chk("err In_ready", 32'(In_ready), 0);
    RST_N = 1'b0;
    step();
    chk_reset("err reset");
    RST_N = 1'b1;
    issue(6'h23, 5'd20);
    chk("mid Busy", Busy, 32'h0010_0000);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    chk_reset("mid reset");
    Mem_rvalid = 1'b1;
    step();
    Mem_rvalid = 1'b0;
    chk("mid stray We", 32'(We), 0);
    chk("mid stray Retired", 32'(Retired), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
